eeprom_cfg_loader: RTL and testbench
====================================

EEPROM_CFG_LOADER -- requirements
Module: eeprom_cfg_loader

Interface
REQ-001 Parameter NUM_BYTES, default 5, number of configuration bytes read (range 1..16).
REQ-002 Parameter GAP_CYCLES, default 2000, idle clocks between an I2C completion and the next command.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, maximum clocks allowed for one I2C command to complete.
REQ-004 Parameter MAX_RETRIES, default 3, re-attempts per byte after a timeout.
REQ-005 Ports, in order:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse to begin a readout.
- base_addr  in  11  EEPROM start byte address.
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky failure flag.
- cfg_data  out  NUM_BYTES*8  byte k at bits [8k+7:8k].
- i2c_enable  out  1  one-cycle command strobe to the controller.
- i2c_rw  out  1  0 = write, 1 = read.
- i2c_addr  out  7  device address.
- i2c_data_in  out  8  word address.
- i2c_data_out  in  8  byte returned by a read.
- i2c_ready  in  1  controller idle.

Function
REQ-006 States SHALL be IDLE, SET_ADDR, WAIT_ADDR, GAP, READ, WAIT_READ, STORE, CHECK, FAIL.
REQ-007 IDLE: on start, the block latches base_addr into cur_addr, clears byte_cnt, retry_cnt and error, and goes to SET_ADDR on the next cycle.
REQ-008 SET_ADDR: the block pulses i2c_enable for one cycle with i2c_rw=0, i2c_addr={4'b1010,cur_addr[10:8]} and i2c_data_in=cur_addr[7:0], then goes to WAIT_ADDR.
REQ-009 WAIT_ADDR and WAIT_READ: completion is the rising edge of i2c_ready, detected against a registered copy. On completion, WAIT_ADDR goes to GAP and WAIT_READ goes to STORE.
REQ-010 GAP: the block waits until i2c_ready=1 and GAP_CYCLES counted clocks have elapsed, then goes to READ. The gap counter does not decrement while i2c_ready=0.
REQ-011 READ: the block pulses i2c_enable with i2c_rw=1 and the same address fields, then goes to WAIT_READ.
REQ-012 STORE: the block writes i2c_data_out into byte slot byte_cnt, increments byte_cnt, increments cur_addr modulo 2048 (0x7FF wraps to 0x000), clears retry_cnt, and goes to CHECK.
REQ-013 CHECK:
- If byte_cnt<NUM_BYTES, go to SET_ADDR after GAP_CYCLES idle clocks.
- Otherwise, pulse done for one cycle (subject to REQ-022) and return to IDLE.
REQ-014 Timeout: a counter runs in WAIT_ADDR and WAIT_READ. If it reaches TIMEOUT_CYCLES, the block increments retry_cnt and restarts the current byte at SET_ADDR. If retry_cnt equals MAX_RETRIES, it goes to FAIL instead.
REQ-015 FAIL: the block sets error=1 and returns to IDLE after one cycle. cfg_data keeps any bytes already stored.
REQ-016 busy SHALL be 1 in every state except IDLE; done and busy are never high together.
REQ-017 start is ignored while busy=1.
REQ-018 start and a timeout can never coincide, because start is only sampled in IDLE.
REQ-019 i2c_enable is never asserted while i2c_ready=0.
REQ-020 Address and rw outputs are held stable from the enable pulse until completion.

Reset
REQ-021 Asserting rst, at any time including mid-transaction, forces:
- State: IDLE.
- Outputs: busy=0, done=0, error=0, i2c_enable=0, i2c_rw=0, i2c_addr=0, i2c_data_in=0, cfg_data=0.
- Counters: all cleared.

Configuration
REQ-022 Macro EEPROM_CFG_CRC_EN:
- When defined: the last stored byte is a CRC-8 (polynomial 0x07, init 0x00, MSB first) over bytes 0..NUM_BYTES-2. The CRC is updated in STORE. At completion, a mismatch goes to FAIL and done is not pulsed.
- When undefined: no CRC logic exists and all NUM_BYTES are payload.

Structure
REQ-023 Package eeprom_cfg_pkg holds the state enum, the device-type prefix constant 4'b1010, and the CRC polynomial constant.
REQ-024 The CRC datapath is a separate sub-module, eeprom_cfg_crc8, instantiated only under EEPROM_CFG_CRC_EN. The I2C controller stays external.

Verification
REQ-025 Bench parameters are GAP_CYCLES=4 and TIMEOUT_CYCLES=100, with an I2C controller model. The required scenarios are:
- Nominal: NUM_BYTES=5, base_addr=0x123, model returns 0x01..0x05 -> cfg_data=0x0504030201, one done pulse, 10 enable pulses, addresses 0x123..0x127.
- Wrap: base_addr=0x7FE, NUM_BYTES=4 -> reads hit 0x7FE, 0x7FF, 0x000, 0x001; i2c_addr goes from 0x57 to 0x50.
- Timeout: model withholds ready on the first read of byte 2 once -> retry, completion with correct data, error=0.
- Fail: ready is withheld permanently -> 4 attempts on byte 0, then error=1, busy=0, no done.
- Reset mid-read: rst asserted in WAIT_READ -> all outputs zero next cycle; a following start completes normally.
- CRC (macro defined): NUM_BYTES=3, data 0x01, 0x02, then CRC byte 0x1B -> done. Corrupting the CRC byte to 0x00 -> error=1 and no done.

Source files
------------

// File: rtl/eeprom_cfg_pkg.sv
// eeprom_cfg_pkg: state encoding and constants shared by the EEPROM config loader files.
package eeprom_cfg_pkg;
    typedef enum logic [3:0] {
        IDLE, SET_ADDR, WAIT_ADDR, GAP, READ, WAIT_READ, STORE, CHECK, FAIL
    } state_t;
    localparam logic [3:0] DEV_PREFIX = 4'b1010;
    localparam logic [7:0] CRC_POLY   = 8'h07;
endpackage

// File: rtl/eeprom_cfg_crc8.sv
// eeprom_cfg_crc8: one-byte CRC-8 update, MSB first, polynomial CRC_POLY.
module eeprom_cfg_crc8
    import eeprom_cfg_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);
    always_comb begin
        crc_o = crc_i ^ data_i;
        for (int i = 0; i < 8; i++)
            crc_o = crc_o[7] ? ({crc_o[6:0], 1'b0} ^ CRC_POLY) : {crc_o[6:0], 1'b0};
    end
endmodule

// File: rtl/eeprom_cfg_loader.sv
// eeprom_cfg_loader: reads NUM_BYTES configuration bytes from an I2C EEPROM through an external controller.
// Define EEPROM_CFG_CRC_EN to treat the last byte as a CRC-8 over the preceding bytes.
module eeprom_cfg_loader
    import eeprom_cfg_pkg::*;
#(
    parameter int NUM_BYTES      = 5,
    parameter int GAP_CYCLES     = 2000,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [10:0]            base_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [NUM_BYTES*8-1:0] cfg_data,
    output logic                   i2c_enable,
    output logic                   i2c_rw,
    output logic [6:0]             i2c_addr,
    output logic [7:0]             i2c_data_in,
    input  logic [7:0]             i2c_data_out,
    input  logic                   i2c_ready
);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    state_t                 state_q;
    logic [10:0]            cur_addr_q;
    logic [4:0]             byte_cnt_q;
    logic [RW-1:0]          retry_q;
    logic [GW-1:0]          gap_q;
    logic [TW-1:0]          to_q;
    logic                   ready_q, done_q, error_q, en_q, rw_q;
    logic [6:0]             addr_q;
    logic [7:0]             din_q;
    logic [NUM_BYTES*8-1:0] cfg_q;
    logic                   crc_ok;

`ifdef EEPROM_CFG_CRC_EN
    logic [7:0] crc_q, crc_d;

    eeprom_cfg_crc8 u_crc (.crc_i(crc_q), .data_i(i2c_data_out), .crc_o(crc_d));

    // The CRC covers every byte but the last, which carries the expected value.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            crc_q <= '0;
        else if (state_q == IDLE)
            crc_q <= '0;
        else if (state_q == STORE && byte_cnt_q < 5'(NUM_BYTES - 1))
            crc_q <= crc_d;

    assign crc_ok = crc_q == cfg_q[8*(NUM_BYTES-1) +: 8];
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            byte_cnt_q <= '0;
            retry_q    <= '0;
            gap_q      <= '0;
            to_q       <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            en_q       <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            cfg_q      <= '0;
        end else begin
            ready_q <= i2c_ready;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    cur_addr_q <= base_addr;
                    byte_cnt_q <= '0;
                    retry_q    <= '0;
                    error_q    <= 1'b0;
                    state_q    <= SET_ADDR;
                end
                // Commands are only issued to an idle controller.
                SET_ADDR, READ: if (i2c_ready) begin
                    en_q    <= 1'b1;
                    rw_q    <= state_q == READ;
                    addr_q  <= {DEV_PREFIX, cur_addr_q[10:8]};
                    din_q   <= cur_addr_q[7:0];
                    to_q    <= '0;
                    state_q <= state_q == READ ? WAIT_READ : WAIT_ADDR;
                end
                WAIT_ADDR, WAIT_READ:
                    if (i2c_ready && !ready_q) begin
                        gap_q   <= GW'(GAP_CYCLES);
                        state_q <= state_q == WAIT_READ ? STORE : GAP;
                    end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        retry_q <= retry_q + 1'b1;
                        state_q <= retry_q == RW'(MAX_RETRIES) ? FAIL : SET_ADDR;
                    end else
                        to_q <= to_q + 1'b1;
                GAP: if (i2c_ready) begin
                    if (gap_q <= GW'(1))
                        state_q <= READ;
                    else
                        gap_q <= gap_q - 1'b1;
                end
                STORE: begin
                    for (int k = 0; k < NUM_BYTES; k++)
                        if (byte_cnt_q == 5'(k))
                            cfg_q[8*k +: 8] <= i2c_data_out;
                    byte_cnt_q <= byte_cnt_q + 1'b1;
                    cur_addr_q <= cur_addr_q + 1'b1;
                    retry_q    <= '0;
                    gap_q      <= GW'(GAP_CYCLES);
                    state_q    <= CHECK;
                end
                CHECK:
                    if (byte_cnt_q < 5'(NUM_BYTES)) begin
                        if (gap_q <= GW'(1))
                            state_q <= SET_ADDR;
                        else
                            gap_q <= gap_q - 1'b1;
                    end else begin
                        done_q  <= crc_ok;
                        state_q <= crc_ok ? IDLE : FAIL;
                    end
                FAIL: begin
                    error_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign error       = error_q;
    assign cfg_data    = cfg_q;
    assign i2c_enable  = en_q;
    assign i2c_rw      = rw_q;
    assign i2c_addr    = addr_q;
    assign i2c_data_in = din_q;
endmodule

// File: tb/tb_eeprom_cfg_loader.sv
// tb_eeprom_cfg_loader: directed bench with an I2C controller model shared by two loader instances.
module tb_eeprom_cfg_loader;
`ifdef EEPROM_CFG_CRC_EN
    localparam int NB_A = 3;
`else
    localparam int NB_A = 5;
`endif
    localparam int NB_B = 4;

    logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0, sel = 1'b0;
    logic [10:0] base = '0;
    logic a_busy, a_done, a_err, a_en, a_rw, b_busy, b_done, b_err, b_en, b_rw;
    logic [6:0] a_addr, b_addr;
    logic [7:0] a_din, b_din;
    logic [NB_A*8-1:0] a_cfg;
    logic [NB_B*8-1:0] b_cfg;
    logic m_rdy = 1'b1;
    logic [7:0] m_dout = '0;
    logic m_en, m_rw, m_busy, m_done;
    logic [6:0] m_addr;
    logic [7:0] m_din;

    int total = 0, bad = 0;
    int n_en = 0, n_rd = 0, n_done = 0, viol = 0, both = 0, lat = 0;
    int rd_base = 0, drop_en = -1;
    bit hang = 1'b0;
    logic [10:0] ptr = '0;
    logic [7:0] tab [16];
    logic [10:0] rd_log [16];
    logic [6:0] a7_log [16];

    always #5 clk = ~clk;

    assign m_en   = sel ? b_en : a_en;
    assign m_rw   = sel ? b_rw : a_rw;
    assign m_addr = sel ? b_addr : a_addr;
    assign m_din  = sel ? b_din : a_din;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_done = sel ? b_done : a_done;

    eeprom_cfg_loader #(.NUM_BYTES(NB_A), .GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base), .busy(a_busy), .done(a_done),
        .error(a_err), .cfg_data(a_cfg), .i2c_enable(a_en), .i2c_rw(a_rw), .i2c_addr(a_addr),
        .i2c_data_in(a_din), .i2c_data_out(m_dout), .i2c_ready(m_rdy));

    eeprom_cfg_loader #(.NUM_BYTES(NB_B), .GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base), .busy(b_busy), .done(b_done),
        .error(b_err), .cfg_data(b_cfg), .i2c_enable(b_en), .i2c_rw(b_rw), .i2c_addr(b_addr),
        .i2c_data_in(b_din), .i2c_data_out(m_dout), .i2c_ready(m_rdy));

    // Controller model: drops ready for 4 cycles per command; a hung or dropped command leaves ready high.
    always @(posedge clk) begin
        if (rst) begin
            m_rdy <= 1'b1;
            lat   <= 0;
        end else if (lat > 0) begin
            lat <= lat - 1;
            if (lat == 1) m_rdy <= 1'b1;
        end else if (m_en) begin
            if (n_en != drop_en && !hang) begin
                m_rdy <= 1'b0;
                lat   <= 4;
                if (m_rw) begin
                    m_dout <= tab[4'(n_rd - rd_base)];
                    rd_log[4'(n_rd - rd_base)] <= ptr;
                    a7_log[4'(n_rd - rd_base)] <= m_addr;
                    n_rd <= n_rd + 1;
                end else
                    ptr <= {m_addr[2:0], m_din};
            end
            n_en <= n_en + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst && m_done) n_done <= n_done + 1;
        if (!rst && m_done && m_busy) both <= both + 1;
        if (!rst && m_en && !m_rdy) viol <= viol + 1;
    end

    task automatic go(input logic s, input logic [10:0] a);
        @(negedge clk);
        sel = s; base = a; rd_base = n_rd;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 3000 && m_busy; i++) @(negedge clk);
        total++;
        if (m_busy) begin bad++; $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", nm, m_busy, i); end
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total += 8;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", a_busy); end
        if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", a_done); end
        if (a_err !== 1'b0) begin bad++; $display("FAIL reset_error: got %b required 0", a_err); end
        if (a_en !== 1'b0) begin bad++; $display("FAIL reset_enable: got %b required 0", a_en); end
        if (a_rw !== 1'b0) begin bad++; $display("FAIL reset_rw: got %b required 0", a_rw); end
        if (a_addr !== 7'h00) begin bad++; $display("FAIL reset_addr: got %h required 00", a_addr); end
        if (a_din !== 8'h00) begin bad++; $display("FAIL reset_din: got %h required 00", a_din); end
        if (a_cfg !== '0) begin bad++; $display("FAIL reset_cfg: got %h required 0", a_cfg); end
    endtask

`ifndef EEPROM_CFG_CRC_EN
    task automatic test_nominal;
        int e0, d0;
        for (int i = 0; i < 16; i++) tab[i] = 8'(i + 1);
        e0 = n_en; d0 = n_done;
        go(1'b0, 11'h123);
        wait_idle("nominal");
        total += 4;
        if (a_cfg !== 40'h0504030201) begin bad++; $display("FAIL nominal_cfg: got %h required 0504030201", a_cfg); end
        if (n_done - d0 != 1) begin bad++; $display("FAIL nominal_done: got %0d pulses required 1", n_done - d0); end
        if (n_en - e0 != 10) begin bad++; $display("FAIL nominal_enables: got %0d required 10", n_en - e0); end
        if (a_err !== 1'b0) begin bad++; $display("FAIL nominal_error: got %b required 0", a_err); end
        for (int k = 0; k < 5; k++) begin
            logic [10:0] ea;
            ea = 11'h123 + 11'(k);
            total++;
            if (rd_log[k] !== ea) begin bad++; $display("FAIL nominal_addr%0d: got %h required %h", k, rd_log[k], ea); end
        end
    endtask

    task automatic test_timeout;
        int e0, d0;
        e0 = n_en; d0 = n_done;
        drop_en = n_en + 5;
        go(1'b0, 11'h123);
        wait_idle("timeout");
        drop_en = -1;
        total += 4;
        if (a_cfg !== 40'h0504030201) begin bad++; $display("FAIL timeout_cfg: got %h required 0504030201", a_cfg); end
        if (a_err !== 1'b0) begin bad++; $display("FAIL timeout_error: got %b required 0", a_err); end
        if (n_done - d0 != 1) begin bad++; $display("FAIL timeout_done: got %0d pulses required 1", n_done - d0); end
        if (n_en - e0 != 12) begin bad++; $display("FAIL timeout_enables: got %0d required 12", n_en - e0); end
    endtask

    task automatic test_fail;
        int e0, d0;
        e0 = n_en; d0 = n_done;
        hang = 1'b1;
        go(1'b0, 11'h040);
        wait_idle("fail");
        hang = 1'b0;
        total += 5;
        if (n_en - e0 != 4) begin bad++; $display("FAIL fail_attempts: got %0d required 4", n_en - e0); end
        if (a_err !== 1'b1) begin bad++; $display("FAIL fail_error: got %b required 1", a_err); end
        if (a_busy !== 1'b0) begin bad++; $display("FAIL fail_busy: got %b required 0", a_busy); end
        if (n_done - d0 != 0) begin bad++; $display("FAIL fail_done: got %0d pulses required 0", n_done - d0); end
        if (a_cfg !== 40'h0504030201) begin bad++; $display("FAIL fail_cfg_kept: got %h required 0504030201", a_cfg); end
    endtask

    task automatic test_wrap;
        int d0;
        logic [10:0] ew [4];
        ew = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        tab[0] = 8'hA1; tab[1] = 8'hB2; tab[2] = 8'hC3; tab[3] = 8'hD4;
        d0 = n_done;
        go(1'b1, 11'h7FE);
        wait_idle("wrap");
        total += 5;
        if (b_cfg !== 32'hD4C3B2A1) begin bad++; $display("FAIL wrap_cfg: got %h required d4c3b2a1", b_cfg); end
        if (a7_log[0] !== 7'h57) begin bad++; $display("FAIL wrap_dev_first: got %h required 57", a7_log[0]); end
        if (a7_log[3] !== 7'h50) begin bad++; $display("FAIL wrap_dev_last: got %h required 50", a7_log[3]); end
        if (n_done - d0 != 1) begin bad++; $display("FAIL wrap_done: got %0d pulses required 1", n_done - d0); end
        if (b_err !== 1'b0) begin bad++; $display("FAIL wrap_error: got %b required 0", b_err); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rd_log[k] !== ew[k]) begin bad++; $display("FAIL wrap_addr%0d: got %h required %h", k, rd_log[k], ew[k]); end
        end
        sel = 1'b0;
    endtask
`else
    task automatic test_crc;
        int d0;
        tab[0] = 8'h01; tab[1] = 8'h02; tab[2] = 8'h1B;
        d0 = n_done;
        go(1'b0, 11'h010);
        wait_idle("crc_good");
        total += 3;
        if (a_cfg !== 24'h1B0201) begin bad++; $display("FAIL crc_good_cfg: got %h required 1b0201", a_cfg); end
        if (n_done - d0 != 1) begin bad++; $display("FAIL crc_good_done: got %0d pulses required 1", n_done - d0); end
        if (a_err !== 1'b0) begin bad++; $display("FAIL crc_good_error: got %b required 0", a_err); end
        tab[2] = 8'h00;
        d0 = n_done;
        go(1'b0, 11'h010);
        wait_idle("crc_bad");
        total += 3;
        if (a_err !== 1'b1) begin bad++; $display("FAIL crc_bad_error: got %b required 1", a_err); end
        if (n_done - d0 != 0) begin bad++; $display("FAIL crc_bad_done: got %0d pulses required 0", n_done - d0); end
        if (a_cfg !== 24'h000201) begin bad++; $display("FAIL crc_bad_cfg: got %h required 000201", a_cfg); end
        tab[2] = 8'h1B;
    endtask
`endif

    task automatic test_reset_mid_read;
        int i, d0;
        logic [NB_A*8-1:0] exp_a;
`ifdef EEPROM_CFG_CRC_EN
        tab[0] = 8'h01; tab[1] = 8'h02; tab[2] = 8'h1B;
`else
        for (int k = 0; k < 16; k++) tab[k] = 8'(8'h30 + k);
`endif
        exp_a = '0;
        for (int k = 0; k < NB_A; k++) exp_a[8*k +: 8] = tab[k];
        go(1'b0, 11'h200);
        for (i = 0; i < 2000 && (n_rd - rd_base) < 3; i++) @(negedge clk);
        total++;
        if ((n_rd - rd_base) < 3) begin bad++; $display("FAIL midrd_reach: got %0d reads required 3", n_rd - rd_base); end
        rst = 1'b1;
        @(negedge clk);
        total += 8;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL midrd_busy: got %b required 0", a_busy); end
        if (a_done !== 1'b0) begin bad++; $display("FAIL midrd_done: got %b required 0", a_done); end
        if (a_err !== 1'b0) begin bad++; $display("FAIL midrd_error: got %b required 0", a_err); end
        if (a_en !== 1'b0) begin bad++; $display("FAIL midrd_enable: got %b required 0", a_en); end
        if (a_rw !== 1'b0) begin bad++; $display("FAIL midrd_rw: got %b required 0", a_rw); end
        if (a_addr !== 7'h00) begin bad++; $display("FAIL midrd_addr: got %h required 00", a_addr); end
        if (a_din !== 8'h00) begin bad++; $display("FAIL midrd_din: got %h required 00", a_din); end
        if (a_cfg !== '0) begin bad++; $display("FAIL midrd_cfg: got %h required 0", a_cfg); end
        rst = 1'b0;
        d0 = n_done;
        go(1'b0, 11'h200);
        wait_idle("midrd_rerun");
        total += 3;
        if (a_cfg !== exp_a) begin bad++; $display("FAIL midrd_rerun_cfg: got %h required %h", a_cfg, exp_a); end
        if (n_done - d0 != 1) begin bad++; $display("FAIL midrd_rerun_done: got %0d pulses required 1", n_done - d0); end
        if (a_err !== 1'b0) begin bad++; $display("FAIL midrd_rerun_error: got %b required 0", a_err); end
    endtask

    task automatic test_protocol;
        total += 2;
        if (viol != 0) begin bad++; $display("FAIL enable_while_busy: got %0d required 0", viol); end
        if (both != 0) begin bad++; $display("FAIL done_with_busy: got %0d required 0", both); end
    endtask

    initial begin
        test_reset;
`ifndef EEPROM_CFG_CRC_EN
        test_nominal;
        test_timeout;
        test_fail;
        test_wrap;
`else
        test_crc;
`endif
        test_reset_mid_read;
        test_protocol;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
